// File: rtl/mr_ifetch_pf_if.sv
`default_nettype none
// ============================================================================
//  Module   : mr_ifetch_pf_if
//  Brief    : Instruction-bus (Wishbone B4 pipelined read) and decode-side
//             bundle for the mr prefetching fetch unit.
//  Revision : 1.0  initial release
// ============================================================================
interface mr_ifetch_pf_if #(
    parameter int XLEN = 32
);
    // Wishbone instruction bus
    logic [XLEN-3:0] adr_o;
    logic [XLEN-1:0] dat_i;
    logic            stb_o;
    logic            stall_i;
    logic            ack_i;
    logic            err_i;
    logic            cyc_o;
    // Decode side
    logic [31:0]     inst;
    logic [XLEN-1:0] inst_pc;
    logic            inst_fault;
    logic            inst_valid;
    logic            id_ready;
    // Writeback redirect
    logic [XLEN-1:0] redir_pc;
    logic            redir_valid;

    // The fetch unit
    modport master (
        output adr_o, stb_o, cyc_o,
        input  dat_i, stall_i, ack_i, err_i,
        output inst, inst_pc, inst_fault, inst_valid,
        input  id_ready,
        input  redir_pc, redir_valid
    );

    // Bus slave, decode and writeback seen as one environment
    modport slave (
        input  adr_o, stb_o, cyc_o,
        output dat_i, stall_i, ack_i, err_i,
        input  inst, inst_pc, inst_fault, inst_valid,
        output id_ready,
        output redir_pc, redir_valid
    );
endinterface
`default_nettype wire

// File: rtl/mr_ifetch_pf.sv
`default_nettype none
// ============================================================================
//  Module   : mr_ifetch_pf
//  Brief    : Prefetching instruction fetch unit. Keeps up to DEPTH pipelined
//             word reads in flight, buffers responses in an in-order FIFO,
//             flushes on redirect and tags bus errors as faulting packets.
//  Revision : 1.0  initial release
// ============================================================================
module mr_ifetch_pf #(
    parameter int              XLEN      = 32,
    parameter int              DEPTH     = 4,
    parameter logic [XLEN-1:0] RESET_VEC = '0
) (
    input  wire logic      clk,
    input  wire logic      rst,
    mr_ifetch_pf_if.master bus
);

    localparam int PW = $clog2(DEPTH);   // pointer width
    localparam int CW = PW + 1;          // counter width, holds 0..DEPTH

    // Registered control state
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [CW-1:0]   count_q,    count_d;
    logic [CW-1:0]   inflight_q, inflight_d;
    logic [CW-1:0]   discard_q,  discard_d;
    logic            halted_q,   halted_d;
    logic            stb_q,      stb_d;
    logic            cyc_q,      cyc_d;
    logic [PW-1:0]   rd_ptr_q,   rd_ptr_d;
    logic [PW-1:0]   wr_ptr_q,   wr_ptr_d;
    logic [PW-1:0]   pq_rd_q,    pq_rd_d;
    logic [PW-1:0]   pq_wr_q,    pq_wr_d;

    // Storage: instruction FIFO and the PC of each issued request
    logic [31:0]     fifo_data_q  [DEPTH];
    logic [XLEN-1:0] fifo_pc_q    [DEPTH];
    logic            fifo_fault_q [DEPTH];
    logic [XLEN-1:0] pcq_q        [DEPTH];

    logic            w_accept;
    logic            w_resp;
    logic            w_drop;
    logic            w_push;
    logic            w_pop;
    logic            w_fifo_we;
    logic [CW:0]     w_credit;

    // Responses with nothing outstanding (e.g. after a reset) are ignored.
    assign w_accept  = stb_q & ~bus.stall_i;
    assign w_resp    = (bus.ack_i | bus.err_i) & (inflight_q != '0);
    assign w_drop    = w_resp & (discard_q != '0);
    assign w_push    = w_resp & ~w_drop;
    assign w_pop     = (count_q != '0) & bus.id_ready;
    assign w_fifo_we = w_push & ~bus.redir_valid;

    // Next-state: issue accounting, FIFO occupancy, redirect flush and credit
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        inflight_d = inflight_q + CW'(w_accept) - CW'(w_resp);
        count_d    = count_q + CW'(w_push) - CW'(w_pop);
        discard_d  = discard_q - CW'(w_drop);
        halted_d   = halted_q | (w_push & bus.err_i);
        rd_ptr_d   = rd_ptr_q + PW'(w_pop);
        wr_ptr_d   = wr_ptr_q + PW'(w_push);
        pq_rd_d    = pq_rd_q + PW'(w_resp);
        pq_wr_d    = pq_wr_q + PW'(w_accept);
        w_credit   = '0;
        stb_d      = 1'b0;
        cyc_d      = 1'b0;

        if (w_accept) begin
            fetch_pc_d = fetch_pc_q + XLEN'(4);
        end

        // Everything still outstanding after this edge belongs to the old
        // stream, so it all becomes discard credit.
        if (bus.redir_valid) begin
            fetch_pc_d = bus.redir_pc & ~XLEN'(3);
            count_d    = '0;
            rd_ptr_d   = wr_ptr_q;
            wr_ptr_d   = wr_ptr_q;
            discard_d  = inflight_d;
            halted_d   = 1'b0;
        end

        // Only request when the FIFO is guaranteed room for every reply.
        w_credit = {1'b0, inflight_d} + {1'b0, count_d};
        stb_d    = ~halted_d & ~bus.redir_valid & (w_credit < (CW+1)'(DEPTH));
        cyc_d    = stb_d | (inflight_d != '0);
    end

    // Control state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q <= RESET_VEC;
            count_q    <= '0;
            inflight_q <= '0;
            discard_q  <= '0;
            halted_q   <= 1'b0;
            stb_q      <= 1'b0;
            cyc_q      <= 1'b0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            pq_rd_q    <= '0;
            pq_wr_q    <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            count_q    <= count_d;
            inflight_q <= inflight_d;
            discard_q  <= discard_d;
            halted_q   <= halted_d;
            stb_q      <= stb_d;
            cyc_q      <= cyc_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            pq_rd_q    <= pq_rd_d;
            pq_wr_q    <= pq_wr_d;
        end
    end

    // Data storage; contents are only meaningful under the occupancy counters
    always_ff @(posedge clk) begin
        if (w_accept) begin
            pcq_q[pq_wr_q] <= fetch_pc_q;
        end
        if (w_fifo_we) begin
            fifo_data_q[wr_ptr_q]  <= bus.dat_i[31:0];
            fifo_pc_q[wr_ptr_q]    <= pcq_q[pq_rd_q];
            fifo_fault_q[wr_ptr_q] <= bus.err_i;
        end
    end

    assign bus.adr_o      = fetch_pc_q[XLEN-1:2];
    assign bus.stb_o      = stb_q;
    assign bus.cyc_o      = cyc_q;
    assign bus.inst_valid = (count_q != '0);
    assign bus.inst       = fifo_data_q[rd_ptr_q];
    assign bus.inst_pc    = fifo_pc_q[rd_ptr_q];
    assign bus.inst_fault = (count_q != '0) & fifo_fault_q[rd_ptr_q];

endmodule
`default_nettype wire

// File: tb/tb_mr_ifetch_pf.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mr_ifetch_pf
//  Brief    : Bench for mr_ifetch_pf: in-order bus slave, queue-based model
//             of requests and buffered instructions, directed scenarios and
//             randomized traffic with redirects, errors and resets.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mr_ifetch_pf;

    localparam int          XLEN  = 32;
    localparam int          DEPTH = 4;
    localparam logic [31:0] RVEC  = 32'h0000_0100;

    logic clk;
    logic rst;

    mr_ifetch_pf_if #(.XLEN(XLEN)) bif ();

    mr_ifetch_pf #(
        .XLEN      (XLEN),
        .DEPTH     (DEPTH),
        .RESET_VEC (RVEC)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bif.master)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        bit          stale;
    } req_t;

    typedef struct {
        logic [31:0] data;
        logic [31:0] pc;
        logic        fault;
    } ent_t;

    // Model state
    req_t        rq[$];       // accepted, not yet answered
    ent_t        fq[$];       // buffered instructions, head first
    logic [31:0] sq[$];       // slave's view: addresses it accepted
    logic [31:0] mpc;
    bit          mhalt;
    bit          m_stb;
    bit          m_cyc;
    bit          m_known;

    // Per-cycle stimulus
    bit          d_rst, d_redir, d_stall, d_ready, d_ack, d_err;
    logic [31:0] d_rpc;

    int n_acc, n_resp;
    int n_pass, n_tot;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tot++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    endtask

    // Compare DUT against the model, then drive this cycle's inputs and
    // advance the model across the coming rising edge.
    task automatic step();
        bit   resp, acc, pop;
        req_t r;
        ent_t e;
        @(negedge clk);
        if (m_known) begin
            chk("inst_valid", bif.inst_valid, fq.size() > 0);
            if (fq.size() > 0) begin
                chk("inst", bif.inst, fq[0].data);
                chk("inst_pc", bif.inst_pc, fq[0].pc);
                chk("inst_fault", bif.inst_fault, fq[0].fault);
            end
            chk("stb_o", bif.stb_o, m_stb);
            chk("cyc_o", bif.cyc_o, m_cyc);
            if (m_stb) chk("adr_o", bif.adr_o, mpc[31:2]);
        end

        resp = !d_rst && d_ack && sq.size() > 0;
        rst             = d_rst;
        bif.stall_i     = d_stall;
        bif.id_ready    = d_ready;
        bif.redir_valid = d_redir;
        bif.redir_pc    = d_rpc;
        bif.ack_i       = resp && !d_err;
        bif.err_i       = resp && d_err;
        bif.dat_i       = resp ? mem(sq[0]) : $urandom;

        if (d_rst) begin
            rq.delete(); fq.delete(); sq.delete();
            mpc = RVEC; mhalt = 0; m_stb = 0; m_cyc = 0; m_known = 1;
            return;
        end
        acc = m_stb && !d_stall;
        pop = fq.size() > 0 && d_ready;
        if (pop) void'(fq.pop_front());
        if (resp) begin
            void'(sq.pop_front());
            n_resp++;
            r = rq.pop_front();
            if (!r.stale) begin
                e.data = mem(r.pc); e.pc = r.pc; e.fault = d_err;
                fq.push_back(e);
                if (d_err) mhalt = 1;
            end
        end
        if (acc) begin
            sq.push_back({bif.adr_o, 2'b00});
            r.pc = mpc; r.stale = 0;
            rq.push_back(r);
            mpc = mpc + 32'd4;
            n_acc++;
        end
        if (d_redir) begin
            fq.delete();
            foreach (rq[i]) rq[i].stale = 1;
            mhalt = 0;
            mpc = d_rpc & ~32'd3;
        end
        m_stb = !d_redir && !mhalt && (rq.size() + fq.size() < DEPTH);
        m_cyc = m_stb || rq.size() != 0;
    endtask

    task automatic set_idle();
        d_rst = 0; d_redir = 0; d_rpc = 0; d_stall = 0; d_ready = 1; d_ack = 1; d_err = 0;
    endtask

    task automatic do_reset();
        d_rst = 1; step(); d_rst = 0;
        n_acc = 0; n_resp = 0;
    endtask

    // Wait (bounded) for the first valid head and pin its PC and data.
    task automatic expect_first(input string name, input logic [31:0] pc);
        bit found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            step();
            if (bif.inst_valid === 1'b1) begin
                found = 1;
                chk({name, "_pc"}, bif.inst_pc, pc);
                chk({name, "_data"}, bif.inst, mem(pc));
            end
        end
        if (!found) chk({name, "_timeout"}, 1'b0, 1'b1);
    endtask

    initial begin
        logic [31:0] cap_pc[$];
        bit          cap_f[$];
        int          acc_mark;
        int          p_stall, p_ack, p_ready;

        clk = 0; rst = 1;
        bif.stall_i = 0; bif.id_ready = 0; bif.redir_valid = 0; bif.redir_pc = 0;
        bif.ack_i = 0; bif.err_i = 0; bif.dat_i = 0;
        n_pass = 0; n_tot = 0; m_known = 0;
        set_idle();
        do_reset();

        // Reset values and streaming with no gaps
        step();
        chk("rst_stb", bif.stb_o, 1'b0);
        chk("rst_cyc", bif.cyc_o, 1'b0);
        chk("rst_valid", bif.inst_valid, 1'b0);
        chk("rst_adr", bif.adr_o, 30'h40);
        step();
        chk("stream_stb", bif.stb_o, 1'b1);
        step();
        step();
        chk("stream0", {bif.inst_valid, bif.inst_pc}, {1'b1, 32'h100});
        step();
        chk("stream1", {bif.inst_valid, bif.inst_pc}, {1'b1, 32'h104});
        step();
        chk("stream2", {bif.inst_valid, bif.inst_pc}, {1'b1, 32'h108});
        for (int i = 0; i < 20; i++) step();

        // Backpressure: FIFO fills to DEPTH, strobe stops, order kept
        do_reset();
        d_ready = 0;
        for (int i = 0; i < 12; i++) step();
        chk("bp_accepts", n_acc, 4);
        chk("bp_stb", bif.stb_o, 1'b0);
        chk("bp_head", bif.inst_pc, 32'h100);
        d_ready = 1;
        step();
        step();
        chk("bp_restb", bif.stb_o, 1'b1);
        chk("bp_next", bif.inst_pc, 32'h104);
        for (int i = 0; i < 15; i++) step();

        // Stall holds the address and the PC
        do_reset();
        d_stall = 1;
        step();
        step();
        for (int i = 0; i < 5; i++) begin
            step();
            chk("stall_adr", bif.adr_o, 30'h40);
        end
        chk("stall_noacc", n_acc, 0);
        d_stall = 0;
        step();
        d_stall = 1;
        step();
        chk("stall_one_acc", n_acc, 1);
        chk("stall_adr_adv", bif.adr_o, 30'h41);
        d_stall = 0;
        for (int i = 0; i < 15; i++) step();

        // Redirect with three requests in flight
        do_reset();
        d_ack = 0;
        for (int i = 0; i < 8; i++) begin
            d_stall = (n_acc >= 3);
            step();
        end
        chk("redir_inflight", n_acc, 3);
        d_redir = 1; d_rpc = 32'h2002;
        step();
        d_redir = 0; d_stall = 0; d_ack = 1;
        expect_first("redir_first", 32'h2000);
        for (int i = 0; i < 15; i++) step();

        // Bus error on the second response halts fetch until redirect
        do_reset();
        for (int i = 0; i < 24; i++) begin
            d_err = (n_resp == 1);
            step();
            if (bif.inst_valid === 1'b1) begin
                cap_pc.push_back(bif.inst_pc);
                cap_f.push_back(bif.inst_fault);
            end
            if (i == 12) acc_mark = n_acc;
        end
        d_err = 0;
        if (cap_pc.size() >= 2) begin
            chk("err_pc0", {cap_pc[0], cap_f[0]}, {32'h100, 1'b0});
            chk("err_pc1", {cap_pc[1], cap_f[1]}, {32'h104, 1'b1});
        end else chk("err_captured", cap_pc.size(), 2);
        chk("err_halt_stb", bif.stb_o, 1'b0);
        chk("err_halt_acc", n_acc, acc_mark);
        d_redir = 1; d_rpc = 32'h300;
        step();
        d_redir = 0;
        expect_first("err_resume", 32'h300);
        for (int i = 0; i < 15; i++) step();

        // Reset with two in flight and two buffered
        do_reset();
        d_ready = 0; d_ack = 0;
        for (int i = 0; i < 8; i++) step();
        d_ack = 1;
        step(); step();
        d_ack = 0;
        chk("mid_resp", n_resp, 2);
        do_reset();
        step();
        chk("mid_stb", bif.stb_o, 1'b0);
        chk("mid_cyc", bif.cyc_o, 1'b0);
        chk("mid_valid", bif.inst_valid, 1'b0);
        chk("mid_adr", bif.adr_o, 30'h40);
        set_idle();
        expect_first("mid_restart", RVEC);

        // Randomized traffic
        p_stall = 0; p_ack = 100; p_ready = 100;
        for (int c = 0; c < 6000; c++) begin
            if (c % 250 == 0) begin
                p_stall = $urandom_range(0, 70);
                p_ack   = $urandom_range(20, 100);
                p_ready = $urandom_range(10, 100);
            end
            d_rst   = ($urandom_range(0, 999) < 2);
            d_stall = ($urandom_range(0, 99) < p_stall);
            d_ack   = ($urandom_range(0, 99) < p_ack);
            d_ready = ($urandom_range(0, 99) < p_ready);
            d_err   = ($urandom_range(0, 99) < 3);
            d_redir = ($urandom_range(0, 99) < 2);
            d_rpc   = $urandom;
            step();
        end
        set_idle();
        for (int i = 0; i < 20; i++) step();

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mr_ifetch_pf.md
Name: mr_ifetch_pf

Overview:
Prefetching instruction fetch unit for the mr core. It issues up to DEPTH pipelined Wishbone (B4 pipelined) word reads ahead of decode and buffers the returned words in an in-order FIFO. It handles PC redirects from writeback by flushing the FIFO and discarding stale in-flight responses. Bus errors are tagged as faulting fetch packets rather than silently dropped. Sits between the instruction bus and mr_decode; replaces the single-outstanding fetcher.

Parameters:
XLEN, 32, datapath/address width; only 32 supported (IALIGN=32).
DEPTH, 4, FIFO entries and maximum in-flight requests; power of 2, 2..16.
RESET_VEC, 32'h0000_0000, fetch PC after reset.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
adr_o  out  XLEN-2  word address of request (pc[XLEN-1:2])
dat_i  in  XLEN  read data
stb_o  out  1  request strobe
stall_i  in  1  slave not accepting request this cycle
ack_i  in  1  response valid, in request order
err_i  in  1  response is a bus error (exclusive with ack_i)
cyc_o  out  1  bus cycle active
inst  out  32  instruction word at FIFO head
inst_pc  out  XLEN  PC of inst
inst_fault  out  1  head entry came from err_i
inst_valid  out  1  FIFO non-empty
id_ready  in  1  decode consumes head when inst_valid&id_ready
redir_pc  in  XLEN  redirect target
redir_valid  in  1  redirect request

Behaviour:
- Reset (rst sampled high at posedge): fetch_pc=RESET_VEC; FIFO count=0; inflight=0; discard=0; halted=0; stb_o=0; cyc_o=0; inst_valid=0; inst_fault=0; adr_o=RESET_VEC[XLEN-1:2]. rst is honoured mid-transaction; responses arriving after reset are not tracked and are ignored. SoC reset must also reset the slave.
- Accept: request accepted when stb_o & !stall_i. On acceptance fetch_pc += 4 (mod 2^XLEN, wraps), inflight += 1.
- Response: ack_i|err_i while inflight>0 decrements inflight. If discard>0, the response decrements discard and is dropped. Otherwise the entry {dat_i, pc, err_i} is pushed, with pc taken from a per-entry PC queue that follows issue order.
- Credit: stb_o is registered. It is high in cycle t+1 iff !halted, no redirect at t, and inflight_next + count_next < DEPTH. FIFO overflow is therefore impossible, and a push never needs backpressure. adr_o = fetch_pc[XLEN-1:2] whenever stb_o=1. adr_o is stable while stb_o & stall_i.
- cyc_o = stb_o | (inflight != 0), registered consistently with stb_o. It drops the cycle after the last outstanding response when no new request is pending.
- Throughput: with stall_i=0, single-cycle ack, and id_ready=1, one instruction per cycle is sustained after a 2-cycle initial latency. Latency runs from stb_o accept to inst_valid: ack cycle + 1.
- FIFO: push and pop in the same cycle are both allowed at any count. Pop on empty is ignored. Outputs come from registered head storage. inst_valid=0 implies inst/inst_pc/inst_fault are don't-care.
- Error: a pushed err_i entry sets halted=1, stopping new requests. Already-issued requests still complete and are pushed. halted clears only on redirect or reset. Decode traps on inst_fault; a fault never masks older valid entries.
- Redirect (redir_valid at posedge t), highest priority after rst:
  - fetch_pc=redir_pc with bits [1:0] forced to 0.
  - FIFO count=0, so inst_valid=0 at t+1.
  - discard = inflight after this cycle's accept/response (a request accepted at t and a response at t are both counted).
  - halted=0.
  - stb_o=0 for cycle t+1; issuing of the new stream may begin at t+2 with adr_o=redir_pc[XLEN-1:2].
  - A stalled pending strobe is withdrawn (no request issued).
  - A pop at t is irrelevant.
- Back-to-back redirects: the latest target wins; discard is recomputed each time.
- New-stream requests may be issued while discard>0. Ordering guarantees that stale responses are drained first.

Test Plan:
- Streaming: reset, RESET_VEC=0x100, stall_i=0, ack every next cycle, id_ready=1 -> inst_pc 0x100,0x104,0x108... on consecutive cycles, with no gaps after the first valid.
- Backpressure: DEPTH=4, id_ready=0, immediate acks -> exactly 4 requests accepted, stb_o low, FIFO holds 0x100..0x10C; id_ready=1 -> stb_o reasserts and the order is preserved.
- Stall: stall_i=1 for 5 cycles with stb_o high -> adr_o constant 0x40 (pc 0x100), no fetch_pc advance; release -> single accept.
- Redirect with 3 in flight: redir_pc=0x2002 while inflight=3 -> 3 following acks dropped, first inst_pc=0x2000 with that request's data, inst_valid stays 0 until then.
- Bus error: 2nd response err_i -> inst 0x100 fault=0, then 0x104 fault=1; no further stb_o until redir_valid; after redirect to 0x300, normal fetch resumes.
- Reset mid-cycle: rst while inflight=2 and FIFO count=2 -> next cycle stb_o=0, cyc_o=0, inst_valid=0, fetch restarts at RESET_VEC.
